// File: rtl/cnn_tile_scheduler.sv
// Loop-nest sequencer for the tiled conv engine: one start pulse walks to/ti/row/col/ki/kj and issues one step per handshake.
// Optional build macro CNN_SCHED_PERF_EN adds stall and step performance counters.
module cnn_tile_scheduler #(
    parameter int N_p  = 4,
    parameter int M_p  = 4,
    parameter int K_p  = 2,
    parameter int R_p  = 4,
    parameter int C_p  = 4,
    parameter int S_p  = 1,
    parameter int Tn_p = 2,
    parameter int Tm_p = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              valid_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              step_v_o,
    input  logic                              step_ready_i,
    output logic [$clog2(M_p):0]              tm_base_o,
    output logic [$clog2(N_p):0]              tn_base_o,
    output logic [$clog2(Tm_p):0]             tm_cnt_o,
    output logic [$clog2(Tn_p):0]             tn_cnt_o,
    output logic [$clog2(R_p):0]              row_o,
    output logic [$clog2(C_p):0]              col_o,
    output logic [$clog2(K_p):0]              ki_o,
    output logic [$clog2(K_p):0]              kj_o,
    output logic [$clog2(R_p*S_p+K_p):0]      in_row_o,
    output logic [$clog2(C_p*S_p+K_p):0]      in_col_o,
    output logic                              first_o,
    output logic                              last_o,
`ifdef CNN_SCHED_PERF_EN
    output logic [31:0]                       stall_cnt_o,
    output logic [31:0]                       step_cnt_o,
`endif
    output logic [1:0]                        state_o
);

    localparam int TMB_W = $clog2(M_p) + 1;
    localparam int TNB_W = $clog2(N_p) + 1;
    localparam int TMC_W = $clog2(Tm_p) + 1;
    localparam int TNC_W = $clog2(Tn_p) + 1;
    localparam int RW    = $clog2(R_p) + 1;
    localparam int CW    = $clog2(C_p) + 1;
    localparam int KW    = $clog2(K_p) + 1;
    localparam int IRW   = $clog2(R_p*S_p+K_p) + 1;
    localparam int ICW   = $clog2(C_p*S_p+K_p) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q;
    logic [TMB_W-1:0]   tm_base_q;
    logic [TNB_W-1:0]   tn_base_q;
    logic [RW-1:0]      row_q;
    logic [CW-1:0]      col_q;
    logic [KW-1:0]      ki_q;
    logic [KW-1:0]      kj_q;
    logic               kj_last, ki_last, col_last, row_last, tn_last, tm_last;
    logic [31:0]        tm_rem, tn_rem;

    assign kj_last  = (kj_q  == KW'(K_p - 1));
    assign ki_last  = (ki_q  == KW'(K_p - 1));
    assign col_last = (col_q == CW'(C_p - 1));
    assign row_last = (row_q == RW'(R_p - 1));
    assign tn_last  = (32'(tn_base_q) + Tn_p >= N_p);
    assign tm_last  = (32'(tm_base_q) + Tm_p >= M_p);
    assign tm_rem   = M_p - 32'(tm_base_q);
    assign tn_rem   = N_p - 32'(tn_base_q);

    // Step handshake: a step transfers on a rising clk_i edge where step_v_o && step_ready_i;
    // while step_v_o is high and step_ready_i is low, every step field holds its value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            tm_base_q <= '0;
            tn_base_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            ki_q      <= '0;
            kj_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        tm_base_q <= '0;
                        tn_base_q <= '0;
                        row_q     <= '0;
                        col_q     <= '0;
                        ki_q      <= '0;
                        kj_q      <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (step_ready_i) begin
                        if (!kj_last) kj_q <= kj_q + 1'b1;
                        else begin
                            kj_q <= '0;
                            if (!ki_last) ki_q <= ki_q + 1'b1;
                            else begin
                                ki_q <= '0;
                                if (!col_last) col_q <= col_q + 1'b1;
                                else begin
                                    col_q <= '0;
                                    if (!row_last) row_q <= row_q + 1'b1;
                                    else begin
                                        row_q <= '0;
                                        if (!tn_last) tn_base_q <= tn_base_q + TNB_W'(Tn_p);
                                        else begin
                                            tn_base_q <= '0;
                                            if (!tm_last) tm_base_q <= tm_base_q + TMB_W'(Tm_p);
                                            else begin
                                                tm_base_q <= '0;
                                                state_q   <= DONE;
                                            end
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign step_v_o = (state_q == RUN);
    assign state_o  = state_q;

    // Step fields are forced to zero outside RUN so idle and reset present an all-zero bus.
    always_comb begin
        tm_base_o = '0;
        tn_base_o = '0;
        tm_cnt_o  = '0;
        tn_cnt_o  = '0;
        row_o     = '0;
        col_o     = '0;
        ki_o      = '0;
        kj_o      = '0;
        in_row_o  = '0;
        in_col_o  = '0;
        first_o   = 1'b0;
        last_o    = 1'b0;
        if (state_q == RUN) begin
            tm_base_o = tm_base_q;
            tn_base_o = tn_base_q;
            tm_cnt_o  = (tm_rem < Tm_p) ? TMC_W'(tm_rem) : TMC_W'(Tm_p);
            tn_cnt_o  = (tn_rem < Tn_p) ? TNC_W'(tn_rem) : TNC_W'(Tn_p);
            row_o     = row_q;
            col_o     = col_q;
            ki_o      = ki_q;
            kj_o      = kj_q;
            in_row_o  = IRW'(32'(row_q) * S_p + 32'(ki_q));
            in_col_o  = ICW'(32'(col_q) * S_p + 32'(kj_q));
            first_o   = (tn_base_q == '0) && (ki_q == '0) && (kj_q == '0);
            last_o    = tn_last && ki_last && kj_last;
        end
    end

`ifdef CNN_SCHED_PERF_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_o <= '0;
            step_cnt_o  <= '0;
        end else if (state_q == IDLE && valid_i) begin
            stall_cnt_o <= '0;
            step_cnt_o  <= '0;
        end else if (state_q == RUN) begin
            if (step_ready_i) begin
                if (step_cnt_o != '1) step_cnt_o <= step_cnt_o + 1'b1;
            end else begin
                if (stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cnn_tile_scheduler.sv
// Bench for cnn_tile_scheduler: default-size instance A and a partial-tile/stride instance B, checked against a loop-nest model.
module tb_cnn_tile_scheduler;

    localparam int AN = 4, AM = 4, AK = 2, AR = 4, AC = 4, AS = 1, ATn = 2, ATm = 2;
    localparam int BN = 5, BM = 3, BK = 3, BR = 2, BC = 2, BS = 2, BTn = 2, BTm = 2;
    localparam int A_TOTAL = 256;
    localparam int B_TOTAL = 216;

    logic clk;
    logic reset;

    logic a_valid, a_ready, a_busy, a_done, a_step_v, a_first, a_last;
    logic [$clog2(AM):0]          a_tm_base;
    logic [$clog2(AN):0]          a_tn_base;
    logic [$clog2(ATm):0]         a_tm_cnt;
    logic [$clog2(ATn):0]         a_tn_cnt;
    logic [$clog2(AR):0]          a_row;
    logic [$clog2(AC):0]          a_col;
    logic [$clog2(AK):0]          a_ki, a_kj;
    logic [$clog2(AR*AS+AK):0]    a_in_row;
    logic [$clog2(AC*AS+AK):0]    a_in_col;
    logic [1:0]                   a_state;

    logic b_valid, b_ready, b_busy, b_done, b_step_v, b_first, b_last;
    logic [$clog2(BM):0]          b_tm_base;
    logic [$clog2(BN):0]          b_tn_base;
    logic [$clog2(BTm):0]         b_tm_cnt;
    logic [$clog2(BTn):0]         b_tn_cnt;
    logic [$clog2(BR):0]          b_row;
    logic [$clog2(BC):0]          b_col;
    logic [$clog2(BK):0]          b_ki, b_kj;
    logic [$clog2(BR*BS+BK):0]    b_in_row;
    logic [$clog2(BC*BS+BK):0]    b_in_col;
    logic [1:0]                   b_state;

`ifdef CNN_SCHED_PERF_EN
    logic [31:0] a_stall_cnt, a_step_cnt, b_stall_cnt, b_step_cnt;
`endif

    logic [95:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    cnn_tile_scheduler #(
        .N_p(AN), .M_p(AM), .K_p(AK), .R_p(AR), .C_p(AC), .S_p(AS), .Tn_p(ATn), .Tm_p(ATm)
    ) u_a (
        .clk_i(clk), .reset_i(reset), .valid_i(a_valid), .busy_o(a_busy), .done_o(a_done),
        .step_v_o(a_step_v), .step_ready_i(a_ready),
        .tm_base_o(a_tm_base), .tn_base_o(a_tn_base), .tm_cnt_o(a_tm_cnt), .tn_cnt_o(a_tn_cnt),
        .row_o(a_row), .col_o(a_col), .ki_o(a_ki), .kj_o(a_kj),
        .in_row_o(a_in_row), .in_col_o(a_in_col), .first_o(a_first), .last_o(a_last),
`ifdef CNN_SCHED_PERF_EN
        .stall_cnt_o(a_stall_cnt), .step_cnt_o(a_step_cnt),
`endif
        .state_o(a_state)
    );

    cnn_tile_scheduler #(
        .N_p(BN), .M_p(BM), .K_p(BK), .R_p(BR), .C_p(BC), .S_p(BS), .Tn_p(BTn), .Tm_p(BTm)
    ) u_b (
        .clk_i(clk), .reset_i(reset), .valid_i(b_valid), .busy_o(b_busy), .done_o(b_done),
        .step_v_o(b_step_v), .step_ready_i(b_ready),
        .tm_base_o(b_tm_base), .tn_base_o(b_tn_base), .tm_cnt_o(b_tm_cnt), .tn_cnt_o(b_tn_cnt),
        .row_o(b_row), .col_o(b_col), .ki_o(b_ki), .kj_o(b_kj),
        .in_row_o(b_in_row), .in_col_o(b_in_col), .first_o(b_first), .last_o(b_last),
`ifdef CNN_SCHED_PERF_EN
        .stall_cnt_o(b_stall_cnt), .step_cnt_o(b_step_cnt),
`endif
        .state_o(b_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [95:0] pk(input int tmb, input int tnb, input int tmc, input int tnc,
                                       input int r, input int c, input int ki, input int kj,
                                       input int ir, input int ic, input int f, input int l);
        return {8'(tmb), 8'(tnb), 8'(tmc), 8'(tnc), 8'(r), 8'(c),
                8'(ki), 8'(kj), 8'(ir), 8'(ic), 8'(f), 8'(l)};
    endfunction

    function automatic logic [95:0] pack_a();
        return pk(int'(a_tm_base), int'(a_tn_base), int'(a_tm_cnt), int'(a_tn_cnt),
                  int'(a_row), int'(a_col), int'(a_ki), int'(a_kj),
                  int'(a_in_row), int'(a_in_col), int'(a_first), int'(a_last));
    endfunction

    function automatic logic [95:0] pack_b();
        return pk(int'(b_tm_base), int'(b_tn_base), int'(b_tm_cnt), int'(b_tn_cnt),
                  int'(b_row), int'(b_col), int'(b_ki), int'(b_kj),
                  int'(b_in_row), int'(b_in_col), int'(b_first), int'(b_last));
    endfunction

    // reference loop nest: every step a layer must issue, in order
    task automatic push_layer(input int n, input int m, input int k, input int r, input int c,
                              input int s, input int tn, input int tm);
        for (int tmb = 0; tmb < m; tmb += tm)
            for (int tnb = 0; tnb < n; tnb += tn)
                for (int rr = 0; rr < r; rr++)
                    for (int cc = 0; cc < c; cc++)
                        for (int ii = 0; ii < k; ii++)
                            for (int jj = 0; jj < k; jj++)
                                exp_q.push_back(pk(tmb, tnb, (m - tmb < tm) ? m - tmb : tm,
                                                   (n - tnb < tn) ? n - tnb : tn, rr, cc, ii, jj,
                                                   rr * s + ii, cc * s + jj,
                                                   (tnb == 0 && ii == 0 && jj == 0) ? 1 : 0,
                                                   (tnb + tn >= n && ii == k - 1 && jj == k - 1) ? 1 : 0));
    endtask

    // driver + scoreboard for instance A; mode 0 ready=1, 1 ready low on odd cycles, 2 random
    task automatic run_a(input int mode, input bit poke, output int steps, output int dones,
                         output int firsts, output int lasts, output int last_acc, output int done_cyc);
        logic [95:0] obs;
        int cyc;
        bit fin;
        steps = 0; dones = 0; firsts = 0; lasts = 0; last_acc = -1; done_cyc = -1; fin = 0;
        push_layer(AN, AM, AK, AR, AC, AS, ATn, ATm);
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        cyc = 0;
        while (!fin && cyc < 3000) begin
            a_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            a_valid = poke && (cyc == 40 || cyc == 41 || steps == A_TOTAL);
            @(negedge clk);
            if (a_step_v) begin
                obs = pack_a();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL a_extra_step: got %h required no step", obs);
                end else if (obs !== exp_q[0]) begin
                    errors++;
                    $display("FAIL a_step %0d: got %h required %h", steps, obs, exp_q[0]);
                end
                if (a_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    steps++;
                    firsts += int'(a_first);
                    lasts  += int'(a_last);
                    last_acc = cyc;
                end
            end
            if (a_done) begin
                dones++;
                done_cyc = cyc;
                fin = 1;
                checks++;
                if (a_busy !== 1'b1 || a_step_v !== 1'b0) begin
                    errors++;
                    $display("FAIL a_done_state: busy %b step_v %b required busy 1 step_v 0", a_busy, a_step_v);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        a_valid = 1'b0;
        a_ready = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL a_timeout: no done after %0d cycles, steps %0d required %0d", cyc, steps, A_TOTAL);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (a_step_v !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
                errors++;
                $display("FAIL a_idle_after_done: step_v %b busy %b done %b required 0 0 0", a_step_v, a_busy, a_done);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; a_valid = 1'b0; a_ready = 1'b0; b_valid = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pack_a() !== 96'd0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_step_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: fields %h busy %b done %b step_v %b required all 0", pack_a(), a_busy, a_done, a_step_v);
        end
        checks++;
        if (pack_b() !== 96'd0 || b_busy !== 1'b0 || b_step_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_b: fields %h busy %b step_v %b required all 0", pack_b(), b_busy, b_step_v);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_full_rate;
        int steps, dones, firsts, lasts, last_acc, done_cyc;
        run_a(0, 1'b0, steps, dones, firsts, lasts, last_acc, done_cyc);
        checks++;
        if (steps !== A_TOTAL || last_acc !== A_TOTAL - 1) begin
            errors++;
            $display("FAIL full_rate_steps: steps %0d last_cycle %0d required %0d and %0d", steps, last_acc, A_TOTAL, A_TOTAL - 1);
        end
        checks++;
        if (dones !== 1 || done_cyc !== last_acc + 1) begin
            errors++;
            $display("FAIL full_rate_done: dones %0d at %0d required 1 at %0d", dones, done_cyc, last_acc + 1);
        end
        checks++;
        if (firsts !== 32 || lasts !== 32) begin
            errors++;
            $display("FAIL first_last_count: first %0d last %0d required 32 32", firsts, lasts);
        end
`ifdef CNN_SCHED_PERF_EN
        checks++;
        if (a_step_cnt !== 32'd256 || a_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_full_rate: step %0d stall %0d required 256 0", a_step_cnt, a_stall_cnt);
        end
`endif
    endtask

    task automatic test_stall_odd;
        int steps, dones, firsts, lasts, last_acc, done_cyc;
        run_a(1, 1'b0, steps, dones, firsts, lasts, last_acc, done_cyc);
        checks++;
        if (steps !== A_TOTAL || last_acc !== 2 * (A_TOTAL - 1)) begin
            errors++;
            $display("FAIL stall_steps: steps %0d last_cycle %0d required %0d and %0d", steps, last_acc, A_TOTAL, 2 * (A_TOTAL - 1));
        end
        checks++;
        if (dones !== 1 || done_cyc !== last_acc + 1) begin
            errors++;
            $display("FAIL stall_done: dones %0d at %0d required 1 at %0d", dones, done_cyc, last_acc + 1);
        end
`ifdef CNN_SCHED_PERF_EN
        checks++;
        if (a_step_cnt !== 32'd256 || (a_stall_cnt !== 32'd255 && a_stall_cnt !== 32'd256)) begin
            errors++;
            $display("FAIL perf_stall: step %0d stall %0d required 256 and 255/256", a_step_cnt, a_stall_cnt);
        end
`endif
    endtask

    task automatic test_restart_ignored;
        int steps, dones, firsts, lasts, last_acc, done_cyc;
        run_a(2, 1'b1, steps, dones, firsts, lasts, last_acc, done_cyc);
        checks++;
        if (steps !== A_TOTAL || dones !== 1) begin
            errors++;
            $display("FAIL restart_ignored: steps %0d dones %0d required %0d 1", steps, dones, A_TOTAL);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL restart_queue: %0d expected steps left, required 0", exp_q.size());
        end
    endtask

    task automatic test_mid_reset;
        int steps, dones, firsts, lasts, last_acc, done_cyc;
        push_layer(AN, AM, AK, AR, AC, AS, ATn, ATm);
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (a_step_v !== 1'b1 || pack_a() !== exp_q[0]) begin
                errors++;
                $display("FAIL mid_reset_step %0d: step_v %b got %h required %h", i, a_step_v, pack_a(), exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        a_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (pack_a() !== 96'd0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_step_v !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: fields %h busy %b done %b step_v %b required all 0", pack_a(), a_busy, a_done, a_step_v);
        end
`ifdef CNN_SCHED_PERF_EN
        checks++;
        if (a_step_cnt !== 32'd0 || a_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: step %0d stall %0d required 0 0", a_step_cnt, a_stall_cnt);
        end
`endif
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (a_done !== 1'b0 || a_busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_done: done %b busy %b required 0 0", a_done, a_busy);
            end
        end
        @(posedge clk); #1;
        exp_q.delete();
        run_a(0, 1'b0, steps, dones, firsts, lasts, last_acc, done_cyc);
        checks++;
        if (steps !== A_TOTAL || dones !== 1) begin
            errors++;
            $display("FAIL restart_after_reset: steps %0d dones %0d required %0d 1", steps, dones, A_TOTAL);
        end
    endtask

    task automatic test_partial_tiles;
        logic [95:0] obs;
        int steps, dones, cyc, hits;
        bit fin;
        steps = 0; dones = 0; cyc = 0; hits = 0; fin = 0;
        exp_q.delete();
        push_layer(BN, BM, BK, BR, BC, BS, BTn, BTm);
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        while (!fin && cyc < 3000) begin
            b_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b_step_v) begin
                obs = pack_b();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_extra_step: got %h required no step", obs);
                end else if (obs !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b_step %0d: got %h required %h", steps, obs, exp_q[0]);
                end
                if (b_row == 1 && b_col == 1 && b_ki == 2 && b_kj == 1) begin
                    hits++;
                    checks++;
                    if (b_in_row !== 4 || b_in_col !== 3) begin
                        errors++;
                        $display("FAIL stride_coords: in_row %0d in_col %0d required 4 3", b_in_row, b_in_col);
                    end
                end
                if (b_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    steps++;
                end
            end
            if (b_done) begin
                dones++;
                fin = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b_ready = 1'b0;
        checks++;
        if (!fin || steps !== B_TOTAL || dones !== 1) begin
            errors++;
            $display("FAIL partial_total: done %0d steps %0d dones %0d required 1 %0d 1", fin, steps, dones, B_TOTAL);
        end
        checks++;
        if (hits == 0) begin
            errors++;
            $display("FAIL stride_point_seen: hits %0d required >0", hits);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall_odd();
        test_restart_ignored();
        test_mid_reset();
        test_partial_tiles();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_tile_scheduler.md
Name: cnn_tile_scheduler

Overview:
- Loop-nest sequencer for the tiled convolution engine (Tm_p x Tn_p MAC array).
- A one-cycle valid_i start launches one full layer. The block then walks the tile and loop nest (to, ti, row, col, ki, kj) and issues one compute step per accepted handshake.
- Each step carries tile bases, output/input coordinates and accumulator control flags. The block sits between the top-level controller and the conv datapath/memory address logic.

Parameters:
- N_p, 4, input feature-map count
- M_p, 4, output feature-map count
- K_p, 2, kernel height/width
- R_p, 4, output rows
- C_p, 4, output columns
- S_p, 1, stride
- Tn_p, 2, input-map tile size
- Tm_p, 2, output-map tile size

Ports:
- clk_i, in, 1, clock
- reset_i, in, 1, synchronous active-high reset
- valid_i, in, 1, start pulse; sampled only in IDLE
- busy_o, out, 1, high in RUN and DONE
- done_o, out, 1, one-cycle pulse after the last step is accepted
- step_v_o, out, 1, step valid
- step_ready_i, in, 1, datapath accepts step
- tm_base_o, out, $clog2(M_p)+1, first output map of the current tile
- tn_base_o, out, $clog2(N_p)+1, first input map of the current tile
- tm_cnt_o, out, $clog2(Tm_p)+1, valid lanes = min(Tm_p, M_p-tm_base)
- tn_cnt_o, out, $clog2(Tn_p)+1, valid lanes = min(Tn_p, N_p-tn_base)
- row_o, out, $clog2(R_p)+1, output row
- col_o, out, $clog2(C_p)+1, output column
- ki_o, out, $clog2(K_p)+1, kernel row
- kj_o, out, $clog2(K_p)+1, kernel column
- in_row_o, out, $clog2(R_p*S_p+K_p)+1, row_o*S_p+ki_o
- in_col_o, out, $clog2(C_p*S_p+K_p)+1, col_o*S_p+kj_o
- first_o, out, 1, clear accumulator: tn_base==0 && ki==0 && kj==0
- last_o, out, 1, write output: last ti tile && ki==K_p-1 && kj==K_p-1

Behaviour:
- Reset, sync, active-high: state=IDLE; all counters and every output = 0. Reset mid-RUN abandons the layer with no done_o.
- States:
  - IDLE: busy_o=0, step_v_o=0. valid_i=1 -> load all counters to 0 -> RUN next cycle.
  - RUN: step_v_o=1. Step fields are combinational functions of the registered counters.
    - step_v_o && step_ready_i advances the nest, innermost first: kj, ki, col, row, ti (tn_base += Tn_p), to (tm_base += Tm_p).
    - step_ready_i=0 holds every output stable.
    - Acceptance of the final step (to, ti, row, col, ki, kj all at their last values) -> DONE.
  - DONE: step_v_o=0, busy_o=1, done_o=1 for exactly one cycle -> IDLE.
- Loop bounds:
  - kj, ki: 0..K_p-1.
  - col: 0..C_p-1; row: 0..R_p-1.
  - tn_base: 0, Tn_p, ... while < N_p.
  - tm_base: 0, Tm_p, ... while < M_p.
- Each counter wraps to 0 when the next outer counter increments.
- Partial tiles: when N_p (or M_p) is not a multiple of Tn_p (or Tm_p), the last tile's tn_cnt_o (or tm_cnt_o) is less than Tn_p (or Tm_p); no extra tile is issued.
- Total accepted steps per layer = ceil(M_p/Tm_p)*ceil(N_p/Tn_p)*R_p*C_p*K_p*K_p. Defaults give 2*2*4*4*2*2 = 256.
- Throughput: one step per cycle while step_ready_i=1. No bubbles between tiles.
- valid_i is ignored in RUN and DONE; a new start is accepted in the IDLE cycle after the done_o pulse.
- Degenerate K_p=1: first_o and last_o are both set on the same step whenever the ti condition holds.
- All arithmetic is unsigned. Width formulas are sized so no counter overflows before compare.

Optional Feature:
- Macro: CNN_SCHED_PERF_EN.
- Defined:
  - Adds outputs stall_cnt_o[31:0], counting cycles in RUN with step_v_o=1 && step_ready_i=0.
  - Adds step_cnt_o[31:0], counting accepted steps.
  - Both clear on reset and on RUN entry, hold value in IDLE/DONE, and saturate at all-ones.
- Undefined: the ports and logic do not exist; behaviour is otherwise identical.

Test Plan:
- Defaults, step_ready_i=1 constantly, valid_i pulse -> exactly 256 accepted steps in 256 consecutive cycles. done_o pulses 1 cycle after the last step. first_o asserted on 32 steps, last_o asserted on 32 steps.
- Defaults, step_ready_i low on every odd cycle -> same 256-step sequence in the same order. Outputs stable during stalls. With CNN_SCHED_PERF_EN: stall_cnt_o=255 or 256 per phase, step_cnt_o=256.
- N_p=5, Tn_p=2, M_p=3, Tm_p=2:
  - tn_base_o sequence 0,2,4 with tn_cnt_o 2,2,1.
  - tm_base_o sequence 0,2 with tm_cnt_o 2,1.
  - Total 2*3*16*4 = 384 steps.
- S_p=2, K_p=3, R_p=C_p=2: at row=1, col=1, ki=2, kj=1 -> in_row_o=4, in_col_o=3.
- Reset asserted at step 100 -> next cycle all outputs 0, IDLE, no done_o. A fresh valid_i restarts from tm_base=tn_base=row=col=ki=kj=0.
- valid_i pulsed again mid-RUN and during DONE -> ignored; step count is still 256 and exactly one done_o.
